// File: rtl/pdh_cmd_regbank.sv
`default_nettype none
// ==== pdh_cmd_regbank : filtered PS->PL command decoder with committed register bank ====
// ==== rev 1.0                                                                         ====
module pdh_cmd_regbank #(
    parameter int          NUM_REGS      = 4,
    parameter int          DATA_W        = 16,
    parameter int          STABLE_CYCLES = 4,
    parameter logic [3:0]  CMD_STROBE    = 4'hE,
    parameter logic [3:0]  CMD_READ      = 4'hF
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic [31:0]                  axi_from_ps_i,
    output logic [31:0]                  axi_to_ps_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          upd_o,
    output logic [7:0]                   led_o
);

    localparam logic [3:0] STAB = 4'(STABLE_CYCLES);
    localparam logic [3:0] NREG = 4'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         in_q;
    logic [3:0]          stab_cnt;
    logic                acc;
    logic                acc_soft;
    logic [3:0]          acc_cmd;
    logic [DATA_W-1:0]   acc_data;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [3:0]          pend_cmd;
    logic [DATA_W-1:0]   pend_data;
    logic [DATA_W-1:0]   callback;
    logic [3:0]          cur_cmd;
    logic [3:0]          last_cmd;
    logic                err;
    logic [6:0]          commit_cnt;

    logic                is_write, is_read, is_strobe, is_invalid;
    logic                load_pend, set_err;
    logic [DATA_W-1:0]   rd_val;
    logic                rd_ok;
    logic [15:0]         cb_ext;

    // Count saturates at STAB so a held word produces a single accept event.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            in_q     <= '0;
            stab_cnt <= '0;
            acc      <= 1'b0;
            acc_soft <= 1'b0;
            acc_cmd  <= '0;
            acc_data <= '0;
        end else begin
            in_q <= axi_from_ps_i;
            acc  <= 1'b0;
            if (axi_from_ps_i != in_q) begin
                stab_cnt <= 4'd1;
            end else if (stab_cnt != STAB) begin
                stab_cnt <= stab_cnt + 4'd1;
                if (stab_cnt == STAB - 4'd1) begin
                    acc      <= 1'b1;
                    acc_soft <= axi_from_ps_i[31];
                    acc_cmd  <= axi_from_ps_i[30:27];
                    acc_data <= axi_from_ps_i[DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        is_write   = (acc_cmd != 4'd0) && (acc_cmd <= NREG);
        is_read    = (acc_cmd == CMD_READ);
        is_strobe  = (acc_cmd == CMD_STROBE);
        is_invalid = !(is_write || is_read || is_strobe || (acc_cmd == 4'd0));
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_pend = 1'b0;
        set_err   = 1'b0;
        if (acc && !acc_soft) begin
            set_err = is_invalid;
            case (state)
                S_IDLE: begin
                    if (is_write || is_read) begin
                        load_pend = 1'b1;
                        state_nxt = S_ARMED;
                    end else if (is_strobe) begin
                        set_err = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (is_write || is_read) load_pend = 1'b1;
                    else if (is_strobe)      state_nxt = S_COMMIT;
                end
                default: ;
            endcase
        end
        if (state == S_COMMIT) state_nxt = S_IDLE;
        if (acc && acc_soft)   state_nxt = S_IDLE;
    end

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (pend_data[3:0] == 4'(k)) begin
                rd_val = regs[k];
                rd_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
            upd_o      <= '0;
            pend_cmd   <= '0;
            pend_data  <= '0;
            callback   <= '0;
            cur_cmd    <= '0;
            last_cmd   <= '0;
            err        <= 1'b0;
            commit_cnt <= '0;
        end else begin
            upd_o <= '0;
            if (acc && acc_soft) begin
                for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
                pend_cmd   <= '0;
                pend_data  <= '0;
                callback   <= '0;
                cur_cmd    <= '0;
                last_cmd   <= '0;
                err        <= 1'b0;
                commit_cnt <= '0;
            end else begin
                if (acc)       cur_cmd <= acc_cmd;
                if (set_err)   err     <= 1'b1;
                if (load_pend) begin
                    pend_cmd  <= acc_cmd;
                    pend_data <= acc_data;
                end
                if (state == S_COMMIT) begin
                    commit_cnt <= commit_cnt + 7'd1;
                    if (pend_cmd == CMD_READ) begin
                        last_cmd <= CMD_READ;
                        callback <= rd_val;
                        if (!rd_ok) err <= 1'b1;
                    end else begin
                        last_cmd <= pend_cmd;
                        callback <= pend_data;
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (pend_cmd == 4'(k + 1)) begin
                                regs[k]  <= pend_data;
                                upd_o[k] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
            assign regs_o[k*DATA_W +: DATA_W] = regs[k];
        end
    endgenerate

    always_comb begin
        cb_ext             = '0;
        cb_ext[DATA_W-1:0] = callback;
    end

    assign axi_to_ps_o = {cb_ext, cur_cmd, last_cmd, err, commit_cnt};
    assign led_o       = regs[0][7:0];

endmodule
`default_nettype wire

// File: tb/tb_pdh_cmd_regbank.sv
`default_nettype none
// ==== tb_pdh_cmd_regbank : scoreboard bench for pdh_cmd_regbank ====
// ==== rev 1.0                                                     ====
module tb_pdh_cmd_regbank;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] axi_in;
    logic [31:0] axi_out;
    logic [63:0] regs_o;
    logic [3:0]  upd_o;
    logic [7:0]  led_o;

    pdh_cmd_regbank dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .axi_from_ps_i (axi_in),
        .axi_to_ps_o   (axi_out),
        .regs_o        (regs_o),
        .upd_o         (upd_o),
        .led_o         (led_o)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] status;
        logic [63:0] regs;
        logic [7:0]  led;
        logic [3:0]  upd;
    } exp_t;

    exp_t commit_q[$];
    exp_t snap_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] STROBE = 32'h7000_0000;
    localparam logic [31:0] SOFT   = 32'h8000_0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic put(input logic [31:0] w, input int n);
        axi_in = w;
        repeat (n) @(negedge clk);
    endtask

    // Expected commit: upd_o must pulse at the 6th edge after the strobe is driven.
    task automatic exp_commit(input logic [3:0] u, input logic [63:0] r, input logic [31:0] s);
        exp_t e;
        e.due = cyc + 6; e.status = s; e.regs = r; e.led = r[7:0]; e.upd = u;
        commit_q.push_back(e);
    endtask

    task automatic exp_snap(input logic [63:0] r, input logic [31:0] s);
        exp_t e;
        e.due = cyc + 1; e.status = s; e.regs = r; e.led = r[7:0]; e.upd = 4'h0;
        snap_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd_o !== 4'h0) begin
                if (commit_q.size() == 0) begin
                    chk("unexpected_upd", {60'h0, upd_o}, 64'h0);
                end else begin
                    e = commit_q.pop_front();
                    chk("commit_cycle",  64'(cyc),      64'(e.due));
                    chk("commit_upd",    {60'h0, upd_o}, {60'h0, e.upd});
                    chk("commit_regs",   regs_o,        e.regs);
                    chk("commit_status", {32'h0, axi_out}, {32'h0, e.status});
                end
            end
            if (snap_q.size() > 0 && snap_q[0].due == cyc) begin
                e = snap_q.pop_front();
                chk("snap_status", {32'h0, axi_out}, {32'h0, e.status});
                chk("snap_regs",   regs_o,           e.regs);
                chk("snap_led",    {56'h0, led_o},   {56'h0, e.led});
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        logic [15:0] d;
        rst_i  = 1'b1;
        axi_in = 32'h0;
        repeat (2) @(negedge clk);
        exp_snap(64'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (8) @(negedge clk);
        exp_snap(64'h0, 32'h0);

        // basic write of reg 0, then commit
        put(32'h0800_00A5, 10);
        exp_commit(4'b0001, 64'h0000_0000_0000_00A5, 32'h00A5_E101);
        put(STROBE, 10);
        exp_snap(64'h0000_0000_0000_00A5, 32'h00A5_E101);

        // write reg 2 then read it back
        put(32'h1800_1234, 10);
        exp_commit(4'b0100, 64'h0000_1234_0000_00A5, 32'h1234_E302);
        put(STROBE, 10);
        put(32'h7800_0002, 10);
        put(STROBE, 10);
        exp_snap(64'h0000_1234_0000_00A5, 32'h1234_EF03);

        // strobe with nothing pending, then an invalid command
        put(32'h0000_0000, 10);
        put(STROBE, 10);
        exp_snap(64'h0000_1234_0000_00A5, 32'h1234_EF83);
        put(32'h4800_7777, 10);
        exp_snap(64'h0000_1234_0000_00A5, 32'h1234_9F83);

        // words never held long enough must not be accepted
        for (int i = 0; i < 10; i++) begin
            put(32'h0800_0055, 2);
            put(32'h0800_00AA, 2);
        end
        exp_snap(64'h0000_1234_0000_00A5, 32'h1234_9F83);
        put(STROBE, 10);
        exp_snap(64'h0000_1234_0000_00A5, 32'h1234_EF83);

        // highest register, out-of-range readback, pending replacement
        put(32'h2000_BEEF, 10);
        exp_commit(4'b1000, 64'hBEEF_1234_0000_00A5, 32'hBEEF_E484);
        put(STROBE, 10);
        put(32'h7800_0005, 10);
        put(STROBE, 10);
        exp_snap(64'hBEEF_1234_0000_00A5, 32'h0000_EF85);
        put(32'h1000_1111, 10);
        put(32'h1000_2222, 10);
        exp_commit(4'b0010, 64'hBEEF_1234_2222_00A5, 32'h2222_E286);
        put(STROBE, 10);

        // soft reset, then 128 commits wrap the counter back to zero
        put(SOFT, 10);
        exp_snap(64'h0, 32'h0);
        for (int i = 0; i < 128; i++) begin
            d = 16'(i * 3 + 1);
            put({16'h0800, d}, 5);
            exp_commit(4'b0001, {48'h0, d}, {d, 4'hE, 4'h1, 1'b0, 7'((i + 1) % 128)});
            put(STROBE, 6);
        end
        exp_snap({48'h0, 16'(127 * 3 + 1)}, {16'(127 * 3 + 1), 16'hE100});
        put(SOFT, 10);
        exp_snap(64'h0, 32'h0);

        // soft reset while armed discards the pending write
        put(32'h0800_5555, 10);
        put(SOFT, 10);
        put(STROBE, 10);
        exp_snap(64'h0, 32'h0000_E080);
        put(SOFT, 10);
        exp_snap(64'h0, 32'h0);

        // rst_i while in COMMIT: write lost, no upd pulse
        put(32'h0800_7777, 10);
        exp_snap(64'h0, 32'h0000_1000);
        put(STROBE, 5);
        rst_i  = 1'b1;
        axi_in = 32'h0;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (10) @(negedge clk);
        exp_snap(64'h0, 32'h0);

        repeat (5) @(negedge clk);
        chk("commit_q_drained", 64'(commit_q.size()), 64'h0);
        chk("snap_q_drained",   64'(snap_q.size()),   64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
